// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg : shared constants, FSM encoding and index-width helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package life_pkg;

  localparam int DEF_ROWS     = 16;
  localparam int DEF_COLS     = 16;
  localparam int DEF_TICK_DIV = 25_000_000;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } ctrl_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_width(input int rows);
    return idx_width(rows);
  endfunction

  function automatic int col_width(input int cols);
    return idx_width(cols);
  endfunction

endpackage

`default_nettype wire

// File: rtl/life_controller_edge_pulse.sv
// ---------------------------------------------------------------------------
// edge_pulse : one-bit rising-edge detector, registered one-cycle pulse
// Rev 1.0 -- optional 2-flop synchronizer under LIFE_KEY_SYNC_EN
// ---------------------------------------------------------------------------
`default_nettype none

module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  logic key_s;
  logic prev;

`ifdef LIFE_KEY_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key};
  end

  assign key_s = sync_q[1];
`else
  assign key_s = key;
`endif

  // History resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      prev  <= key_s;
      pulse <= key_s & ~prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/life_controller.sv
// ---------------------------------------------------------------------------
// life_controller : keys/run switch -> cell write strobes and generation pulses
// Rev 1.0 -- optional input synchronizers under LIFE_KEY_SYNC_EN
// ---------------------------------------------------------------------------
`default_nettype none

module life_controller
  import life_pkg::*;
#(
  parameter  int ROWS     = DEF_ROWS,
  parameter  int COLS     = DEF_COLS,
  parameter  int TICK_DIV = DEF_TICK_DIV,
  localparam int RW       = row_width(ROWS),
  localparam int CW       = col_width(COLS),
  localparam int TW       = idx_width(TICK_DIV)
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic            KeyUp,
  input  logic            KeyDown,
  input  logic            KeyLeft,
  input  logic            KeyRight,
  input  logic            KeyWrite,
  input  logic            KeyStep,
  input  logic            DrawVal,
  input  logic            RunSw,
  output logic [ROWS-1:0] RowSelect,
  output logic [COLS-1:0] ColumnSelect,
  output logic            Input,
  output logic            State,
  output logic            Running,
  output logic [RW-1:0]   CursorRow,
  output logic [CW-1:0]   CursorCol
);

  localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_LAST  = CW'(COLS - 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [ROWS-1:0] ROW_ONE   = {{(ROWS-1){1'b0}}, 1'b1};
  localparam logic [COLS-1:0] COL_ONE   = {{(COLS-1){1'b0}}, 1'b1};

  logic [5:0] keys_raw;
  logic [5:0] key_edge;
  logic       up_e, dn_e, lf_e, rt_e, wr_e, st_e;
  logic       run_sw;

  assign keys_raw = {KeyUp, KeyDown, KeyLeft, KeyRight, KeyWrite, KeyStep};
  assign {up_e, dn_e, lf_e, rt_e, wr_e, st_e} = key_edge;

  for (genvar i = 0; i < 6; i++) begin : g_key
    edge_pulse u_edge (
      .clk   (Clock),
      .rst_n (ResetN),
      .key   (keys_raw[i]),
      .pulse (key_edge[i])
    );
  end

`ifdef LIFE_KEY_SYNC_EN
  logic [1:0] run_sync;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) run_sync <= 2'b00;
    else         run_sync <= {run_sync[0], RunSw};
  end

  assign run_sw = run_sync[1];
`else
  assign run_sw = RunSw;
`endif

  ctrl_state_t     state, state_n;
  logic [TW-1:0]   tick, tick_n;
  logic [RW-1:0]   row_n;
  logic [CW-1:0]   col_n;
  logic [ROWS-1:0] row_sel_n;
  logic [COLS-1:0] col_sel_n;
  logic            input_n, pulse_n, running_n;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= EDIT;
      tick         <= '0;
      CursorRow    <= '0;
      CursorCol    <= '0;
      RowSelect    <= '0;
      ColumnSelect <= '0;
      Input        <= 1'b0;
      State        <= 1'b0;
      Running      <= 1'b0;
    end else begin
      state        <= state_n;
      tick         <= tick_n;
      CursorRow    <= row_n;
      CursorCol    <= col_n;
      RowSelect    <= row_sel_n;
      ColumnSelect <= col_sel_n;
      Input        <= input_n;
      State        <= pulse_n;
      Running      <= running_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      EDIT: begin
        if (run_sw)    state_n = RUN;
        else if (st_e) state_n = STEP;
      end
      STEP:    state_n = EDIT;
      RUN:     if (!run_sw) state_n = EDIT;
      default: state_n = EDIT;
    endcase
  end

  always_comb begin
    tick_n    = '0;
    row_n     = CursorRow;
    col_n     = CursorCol;
    row_sel_n = '0;
    col_sel_n = '0;
    input_n   = 1'b0;
    pulse_n   = (state_n == STEP);
    running_n = (state_n == RUN);

    // Leaving RUN (run_sw low) clears the counter and suppresses a wrap pulse.
    if (state == RUN && run_sw) begin
      if (tick == TICK_LAST) pulse_n = 1'b1;
      else                   tick_n  = tick + TW'(1);
    end

    if (state == EDIT) begin
      if (up_e && !dn_e)      row_n = (CursorRow == '0)       ? ROW_LAST : CursorRow - RW'(1);
      else if (dn_e && !up_e) row_n = (CursorRow == ROW_LAST) ? '0       : CursorRow + RW'(1);

      if (lf_e && !rt_e)      col_n = (CursorCol == '0)       ? COL_LAST : CursorCol - CW'(1);
      else if (rt_e && !lf_e) col_n = (CursorCol == COL_LAST) ? '0       : CursorCol + CW'(1);

      // Strobe uses the pre-move cursor; a concurrent step takes precedence.
      if (wr_e && !st_e && !run_sw) begin
        row_sel_n = ROW_ONE << CursorRow;
        col_sel_n = COL_ONE << CursorCol;
        input_n   = DrawVal;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/life_controller.md
# life_controller

Control stage directly upstream of the per-cell update logic in the Game of Life grid. Converts debounced user keys and a run switch into the grid-wide control signals: one-cycle write strobes (one-hot row/column select plus draw value) in edit mode, and one-cycle generation-advance pulses (`State`), either periodic in run mode or single-step in edit mode. It also exports the cursor position to the display path.

## Interface
Parameters:
- `ROWS`, default 16: grid rows; must be ≥ 2.
- `COLS`, default 16: grid columns; must be ≥ 2.
- `TICK_DIV`, default 25_000_000: clocks per generation in run mode; must be ≥ 2.

Ports:
- `Clock`, in, 1: single clock; all logic on its rising edge.
- `ResetN`, in, 1: reset, asynchronous, active-low.
- `KeyUp`, `KeyDown`, `KeyLeft`, `KeyRight`, in, 1 each: debounced level inputs that move the cursor.
- `KeyWrite`, in, 1: level input; each press writes `DrawVal` to the cell under the cursor.
- `KeyStep`, in, 1: level input; each press in edit mode advances one generation.
- `DrawVal`, in, 1: value to write (1 = alive).
- `RunSw`, in, 1: 1 = run mode, 0 = edit mode.
- `RowSelect`, out, ROWS: one-hot write row strobe; all-zero when idle.
- `ColumnSelect`, out, COLS: one-hot write column strobe; all-zero when idle.
- `Input`, out, 1: registered copy of `DrawVal`, valid with the strobes.
- `State`, out, 1: generation-advance pulse.
- `Running`, out, 1: high while the FSM is in RUN.
- `CursorRow`, out, $clog2(ROWS): current cursor row.
- `CursorCol`, out, $clog2(COLS): current cursor column.

## Operation
- Key inputs pass through rising-edge detection. Each 0→1 transition is one action, regardless of how long the key is held.
- Previous-value registers reset to 1, so a key held through reset does not act.
- FSM states:
  - EDIT: cursor moves and writes are allowed. `RunSw`=1 → RUN. A `KeyStep` edge → STEP.
  - STEP: lasts exactly one cycle, during which `State`=1. Always returns to EDIT.
  - RUN: cursor and write keys are ignored. The tick counter counts 0..TICK_DIV-1 and wraps; `State`=1 for the one cycle after the counter reaches TICK_DIV-1. `RunSw`=0 → EDIT and the counter clears to 0.
- Cursor movement:
  - Up/Down step the row by ∓1 and Left/Right step the column by ∓1, all modulo ROWS/COLS.
  - Up at row 0 goes to ROWS-1; Right at COLS-1 goes to 0.
  - Up and Down edges in the same cycle: no row change. Left and Right in the same cycle: no column change.
- Write (EDIT only):
  - `RowSelect` = 1<<CursorRow, `ColumnSelect` = 1<<CursorCol, `Input` = `DrawVal`, for exactly one cycle.
  - The write uses the cursor value before any movement edge sampled in the same cycle.
- Simultaneous write and step edges in EDIT: the step wins and the write is dropped, because `State`=1 overrides select at the cell anyway.
- Reset values: FSM=EDIT, `RowSelect`=0, `ColumnSelect`=0, `Input`=0, `State`=0, `Running`=0, `CursorRow`=0, `CursorCol`=0, tick counter=0.

## Timing
- All outputs are registered.
- Key edge sampled at rising edge k → strobe, `State` or cursor update visible after edge k+1 (one-cycle latency).
- `State` is never high for two consecutive cycles.
- `RowSelect`/`ColumnSelect` are never nonzero while `State`=1.
- RUN entry: `RunSw` sampled high at edge k; the first `State` pulse follows edge k+TICK_DIV; later pulses follow every TICK_DIV cycles.
- `RunSw` dropping on the same cycle the counter wraps: no pulse is emitted.
- `ResetN` asserted mid-operation: all state clears immediately (asynchronous); any pending strobe or pulse is lost.
- Tick counter width: $clog2(TICK_DIV). The comparison is exact; there is no overflow.

## Configuration
- `LIFE_KEY_SYNC_EN`:
  - Defined: each key input and `RunSw` passes through a 2-flop synchronizer (reset to 1 for keys, 0 for `RunSw`) before edge detection. Every latency in Timing grows by 2 cycles.
  - Undefined: inputs are assumed synchronous to `Clock` and are used directly.

## Structure
- `life_pkg` holds:
  - default ROWS/COLS/TICK_DIV constants;
  - the FSM enum typedef `ctrl_state_t` {EDIT, STEP, RUN};
  - the cursor-index width functions.
- Sub-module `edge_pulse`: one-bit rising-edge detector with reset-to-1 history (and the optional synchronizer). It is instanced once per key.

## Test plan
All scenarios use ROWS=COLS=4 and TICK_DIV=5.
- Reset, then press Up once → `CursorRow`=3 one cycle after the edge; a held key produces no further moves.
- Cursor at (2,1), `DrawVal`=1, press `KeyWrite` → `RowSelect`=4'b0100, `ColumnSelect`=4'b0010, `Input`=1 for exactly one cycle, then zeros.
- `KeyStep` press in EDIT → `State`=1 for one cycle and `Running` stays 0. `KeyStep` and `KeyWrite` in the same cycle → `State` pulse only, no strobe.
- `RunSw` 0→1 → `Running`=1, then `State` pulses every 5 cycles. Cursor and write keys during RUN cause no change. `RunSw`→0 → counter clears, and re-entry gives the first pulse 5 cycles later.
- Right from column 3, and Left+Right pressed together → column wraps to 0, then stays unchanged.
- Assert `ResetN` during RUN mid-count → all outputs 0 asynchronously, FSM=EDIT after release.
